// File: rtl/interp_pkg.sv
// Shared constants and helpers for the interpolator bank loader:
// lane/bank counts, mux select encodings and bank pointer arithmetic.
package interp_pkg;

    localparam int NUM_LANES = 16;
    localparam int NUM_BANKS = 3;

    localparam logic [1:0] SEL_BANK0 = 2'b00;
    localparam logic [1:0] SEL_BANK1 = 2'b10;
    localparam logic [1:0] SEL_BANK2 = 2'b11;

    typedef enum logic [1:0] {
        BANK0 = 2'd0,
        BANK1 = 2'd1,
        BANK2 = 2'd2
    } bank_e;

    function automatic int lane_width(input int data_width);
        return data_width + 2;
    endfunction

    function automatic bank_e next_bank(input bank_e b);
        bank_e n;
        case (b)
            BANK0:   n = BANK1;
            BANK1:   n = BANK2;
            default: n = BANK0;
        endcase
        return n;
    endfunction

    function automatic logic [NUM_BANKS-1:0] bank_onehot(input bank_e b);
        logic [NUM_BANKS-1:0] oh;
        case (b)
            BANK0:   oh = 3'b001;
            BANK1:   oh = 3'b010;
            default: oh = 3'b100;
        endcase
        return oh;
    endfunction

    function automatic logic [1:0] sel_code(input bank_e b);
        logic [1:0] s;
        case (b)
            BANK0:   s = SEL_BANK0;
            BANK1:   s = SEL_BANK1;
            default: s = SEL_BANK2;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/demux3x1_loader_if.sv
// Sample stream in, three flat bank buses plus select/valid/ack out.
interface demux3x1_loader_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int LW = interp_pkg::lane_width(DATA_WIDTH);
    localparam int BW = interp_pkg::NUM_LANES * LW;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [LW-1:0] in_data;
    logic [BW-1:0]        out_bank0;
    logic [BW-1:0]        out_bank1;
    logic [BW-1:0]        out_bank2;
    logic                 c0;
    logic                 c1;
    logic                 out_valid;
    logic                 out_ack;

    modport slave (
        input  in_valid, in_data, out_ack,
        output in_ready, out_bank0, out_bank1, out_bank2, c0, c1, out_valid
    );

    modport master (
        output in_valid, in_data, out_ack,
        input  in_ready, out_bank0, out_bank1, out_bank2, c0, c1, out_valid
    );

endinterface

// File: rtl/lane_bank16.sv
// One 16-lane sample register bank: single write port, all lanes visible
// on a flat registered bus.
module lane_bank16
    import interp_pkg::*;
#(
    parameter int LW = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [3:0]              addr,
    input  logic [LW-1:0]           wdata,
    output logic [NUM_LANES*LW-1:0] bus_o
);

    logic [LW-1:0] lane_q [NUM_LANES];
    logic [LW-1:0] lane_d [NUM_LANES];

    always_comb begin
        lane_d = lane_q;
        if (we) begin
            lane_d[addr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            lane_q <= lane_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_pack
            assign bus_o[gi*LW +: LW] = lane_q[gi];
        end
    endgenerate

endmodule

// File: rtl/demux3x1_loader.sv
// Round-robin loader for three 16-lane banks feeding the 3:1 sample mux;
// tracks per-bank full flags and presents the oldest full bank downstream.
module demux3x1_loader
    import interp_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    demux3x1_loader_if.slave   bus
);

    localparam int LW = lane_width(DATA_WIDTH);
    localparam int BW = NUM_LANES * LW;

    bank_e                wr_bank_q, wr_bank_d;
    logic [3:0]           wr_lane_q, wr_lane_d;
    bank_e                rd_bank_q, rd_bank_d;
    logic [NUM_BANKS-1:0] full_q, full_d;
    logic                 out_valid_q, out_valid_d;
    logic [1:0]           sel_q, sel_d;

    logic                 in_ready;
    logic                 xfer;
    logic                 ack;
    logic [BW-1:0]        bank_bus [NUM_BANKS];

    // Ready depends only on registered state, never on in_valid or out_ack.
    assign in_ready = ~|(full_q & bank_onehot(wr_bank_q));
    assign xfer     = bus.in_valid & in_ready;
    assign ack      = out_valid_q & bus.out_ack;

    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_lane_d = wr_lane_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;

        if (xfer) begin
            wr_lane_d = wr_lane_q + 4'd1;
            if (wr_lane_q == 4'd15) begin
                full_d    = full_d | bank_onehot(wr_bank_q);
                wr_bank_d = next_bank(wr_bank_q);
            end
        end

        if (ack) begin
            full_d    = full_d & ~bank_onehot(rd_bank_q);
            rd_bank_d = next_bank(rd_bank_q);
        end

        // A fresh fill shows up one cycle late; after an ack the next bank's
        // flag is presented immediately alongside its select code.
        if (ack) begin
            out_valid_d = |(full_d & bank_onehot(rd_bank_d));
        end else begin
            out_valid_d = |(full_q & bank_onehot(rd_bank_q));
        end

        sel_d = sel_code(rd_bank_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q   <= BANK0;
            wr_lane_q   <= '0;
            rd_bank_q   <= BANK0;
            full_q      <= '0;
            out_valid_q <= 1'b0;
            sel_q       <= SEL_BANK0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_lane_q   <= wr_lane_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            sel_q       <= sel_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            lane_bank16 #(
                .LW (LW)
            ) u_bank (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (xfer && (wr_bank_q == bank_e'(gi))),
                .addr  (wr_lane_q),
                .wdata (bus.in_data),
                .bus_o (bank_bus[gi])
            );
        end
    endgenerate

    assign bus.in_ready  = in_ready;
    assign bus.out_bank0 = bank_bus[0];
    assign bus.out_bank1 = bank_bus[1];
    assign bus.out_bank2 = bank_bus[2];
    assign bus.c0        = sel_q[0];
    assign bus.c1        = sel_q[1];
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_demux3x1_loader.sv
// Directed bench for the three-bank loader: fill order, select sequencing,
// backpressure, stray acks, overlapping fill/ack, extremes and mid-fill reset.
module tb_demux3x1_loader;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    demux3x1_loader_if #(.DATA_WIDTH(8)) bus ();

    demux3x1_loader #(.DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] lane(input int b, input int k);
        logic [9:0] v;
        case (b)
            0:       v = bus.out_bank0[k*10 +: 10];
            1:       v = bus.out_bank1[k*10 +: 10];
            default: v = bus.out_bank2[k*10 +: 10];
        endcase
        return v;
    endfunction

    function automatic logic [1:0] sel();
        return {bus.c1, bus.c0};
    endfunction

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ack  = 1'b0;
        rst_n        = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input int v);
        bus.in_valid = 1'b1;
        bus.in_data  = 10'(v);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.out_ack = 1'b1;
        tick();
        bus.out_ack = 1'b0;
    endtask

    initial begin
        logic [9:0] e;
        total = 0;
        bad   = 0;
        rst_n = 1'b1;

        // Reset, then one full bank of 0..15
        do_reset();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sel", 32'(sel()), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_bank0", 32'(bus.out_bank0 == '0), 32'd1);
        for (int i = 0; i < 16; i++) push(i);
        chk("t1_valid_lat0", 32'(bus.out_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_sel", 32'(sel()), 32'd0);
        for (int k = 0; k < 16; k++) chk($sformatf("t1_lane%0d", k), 32'(lane(0, k)), k);

        // 48 samples, no ack: all banks full and backpressure
        do_reset();
        for (int i = 0; i < 48; i++) push(i - 5);
        chk("t2_ready_low", 32'(bus.in_ready), 32'd0);
        e = 10'h3FB;
        chk("t2_b0_l0", 32'(lane(0, 0)), 32'(e));
        chk("t2_b1_l0", 32'(lane(1, 0)), 32'd11);
        chk("t2_b2_l15", 32'(lane(2, 15)), 32'd42);
        bus.in_valid = 1'b1;
        bus.in_data  = 10'd99;
        tick();
        bus.in_valid = 1'b0;
        chk("t2_still_low", 32'(bus.in_ready), 32'd0);
        chk("t2_no_overwrite", 32'(lane(0, 0)), 32'(e));
        chk("t2_sel0", 32'(sel()), 32'b00);
        chk("t2_valid0", 32'(bus.out_valid), 32'd1);
        ack_pulse();
        chk("t2_sel1", 32'(sel()), 32'b10);
        chk("t2_valid1", 32'(bus.out_valid), 32'd1);
        chk("t2_ready_after_ack", 32'(bus.in_ready), 32'd1);
        ack_pulse();
        chk("t2_sel2", 32'(sel()), 32'b11);
        chk("t2_valid2", 32'(bus.out_valid), 32'd1);
        ack_pulse();
        chk("t2_sel3", 32'(sel()), 32'b00);
        chk("t2_valid3", 32'(bus.out_valid), 32'd0);

        // Stray ack with out_valid low is ignored
        ack_pulse();
        chk("t3_sel", 32'(sel()), 32'b00);
        chk("t3_valid", 32'(bus.out_valid), 32'd0);
        chk("t3_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 16; i++) push(200 + i);
        tick();
        chk("t3_valid_after_fill", 32'(bus.out_valid), 32'd1);
        chk("t3_sel_after_fill", 32'(sel()), 32'b00);
        chk("t3_b0_l3", 32'(lane(0, 3)), 32'd203);

        // Bank1 completes on the edge that acks bank0
        for (int i = 0; i < 15; i++) push(300 + i);
        bus.out_ack = 1'b1;
        push(315);
        bus.out_ack = 1'b0;
        chk("t4_sel", 32'(sel()), 32'b10);
        chk("t4_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_ready", 32'(bus.in_ready), 32'd1);
        chk("t4_b1_l15", 32'(lane(1, 15)), 32'(10'(315)));
        tick();
        chk("t4_valid_hold", 32'(bus.out_valid), 32'd1);
        ack_pulse();
        chk("t4_sel_next", 32'(sel()), 32'b11);
        chk("t4_valid_next", 32'(bus.out_valid), 32'd0);

        // Signed extremes pass through bit-exact
        do_reset();
        push(-512);
        push(511);
        chk("t5_neg", 32'(lane(0, 0)), 32'h200);
        chk("t5_pos", 32'(lane(0, 1)), 32'h1FF);
        chk("t5_partial_valid", 32'(bus.out_valid), 32'd0);

        // Reset mid-fill of bank1
        do_reset();
        for (int i = 0; i < 16; i++) push(i + 1);
        for (int i = 0; i < 7; i++) push(50 + i);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_async_sel", 32'(sel()), 32'd0);
        chk("t6_async_ready", 32'(bus.in_ready), 32'd1);
        chk("t6_async_b0", 32'(bus.out_bank0 == '0), 32'd1);
        chk("t6_async_b1", 32'(bus.out_bank1 == '0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) push(100 + i);
        chk("t6_b0_l0", 32'(lane(0, 0)), 32'd100);
        chk("t6_b1_l0", 32'(lane(1, 0)), 32'd0);
        tick();
        chk("t6_valid", 32'(bus.out_valid), 32'd1);
        chk("t6_sel", 32'(sel()), 32'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/demux3x1_loader.md
# demux3x1_loader

Write-side counterpart of the 3-bank, 16-lane sample multiplexer in the interpolator datapath. The block accepts a serial stream of signed samples and fills three 16-lane register banks in round-robin order. For each bank it tracks full/empty state and drives the `c0`/`c1` select code that points the downstream 3:1 mux at the oldest full bank. A valid/ack handshake releases each bank once the interpolation core has consumed it, so loading and processing overlap across the three banks.

## Interface
- `DATA_WIDTH`, default 8: base sample width; every lane is `DATA_WIDTH+2` bits, signed.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `in_valid` in, 1: `in_data` holds a sample this cycle.
- `in_ready` out, 1: the loader accepts a sample this cycle. Transfer occurs when `in_valid && in_ready`.
- `in_data` in, `DATA_WIDTH+2`, signed: input sample.
- `out_bank0`, `out_bank1`, `out_bank2` out, `16*(DATA_WIDTH+2)` each: flat lane buses, registered. Lane k occupies `[k*(DATA_WIDTH+2) +: DATA_WIDTH+2]` and feeds mux lanes `in_k`, `in_16+k`, `in_32+k` respectively.
- `c0`, `c1` out, 1 each: mux select, registered. Encoding: bank0 = `c1c0 = 00`, bank1 = `10`, bank2 = `11`. Code `01` is never driven.
- `out_valid` out, 1: the bank addressed by `c1c0` is full and stable.
- `out_ack` in, 1: the consumer releases the current bank. Honoured only when `out_valid` is high.

## Operation
- State: `wr_bank` (0..2), `wr_lane` (0..15), `rd_bank` (0..2), `full[2:0]`.
- Write path:
  - `in_ready = !full[wr_bank]`.
  - On each transfer, `in_data` is written to lane `wr_lane` of bank `wr_bank` and `wr_lane` increments.
  - On the transfer into lane 15: set `full[wr_bank]`, reset `wr_lane` to 0, and advance `wr_bank` (2 wraps to 0).
- Read path:
  - `out_valid = full[rd_bank]`, registered.
  - `c1c0` follows the encoding of `rd_bank`.
  - On `out_valid && out_ack`: clear `full[rd_bank]` and advance `rd_bank` (2 wraps to 0).
  - `out_ack` while `out_valid` is low is ignored.
- Bank contents are never cleared by ack. A bank holds its stale data until it is overwritten lane by lane.
- Simultaneous fill-complete and ack on the same bank cannot occur, because a bank being written is not full. Fill-complete on one bank and ack on another in the same cycle both take effect.
- All three banks full: `in_ready` stays low until an ack arrives; no sample is lost or overwritten.
- Arithmetic: none on sample data. Samples pass through bit-exact, signed, with no extension or truncation.

## Timing
- Reset values (async assert, sync-safe deassert):
  - `wr_bank = wr_lane = rd_bank = 0`, `full = 000`.
  - `out_valid = 0`, `c1c0 = 00`, all bank buses all-zero.
  - `in_ready = 1` combinationally.
- Reset asserted mid-fill or mid-consume discards all progress. Partial banks are not flagged full.
- Fill latency: when the 16th sample of the bank at `rd_bank` is accepted at edge N, `out_valid` is high after edge N+1 (one registered cycle). Bank data is stable from edge N.
- Ack: with ack accepted at edge M, `c1c0` shows the next bank after edge M. `out_valid` after edge M reflects that bank's `full` flag.
- `in_ready` is combinational from registered `full`/`wr_bank` only. There is no combinational path from `in_valid` or `out_ack` to `in_ready`.
- Throughput: one sample per cycle sustained while the consumer acks within 32 cycles of `out_valid`.

## Structure
- Shared package `interp_pkg` holds:
  - `NUM_LANES = 16`, `NUM_BANKS = 3`.
  - The select-code constants `SEL_BANK0 = 2'b00`, `SEL_BANK1 = 2'b10`, `SEL_BANK2 = 2'b11`.
  - A lane-width function of `DATA_WIDTH`.
- Sub-module `lane_bank16`: one 16-lane register bank with write-enable, 4-bit lane address, data in, and flat bus out. It is instantiated three times.
- The top holds the pointers, full flags, and select/valid registers.

## Test plan
- Reset then 16 samples 0..15 with continuous `in_valid` -> `out_bank0` lanes 0..15 = 0..15; `out_valid` high one cycle after the 16th sample; `c1c0 = 00`.
- 48 samples (-5, then incrementing) with no ack -> all `full` bits set, `in_ready` low on the 49th cycle, bank2 lane 15 = 42. Ack three times -> `c1c0` sequence `00`, `10`, `11`, `00`, and `out_valid` low after the third ack.
- Ack pulse while `out_valid = 0` -> no change to `rd_bank`, `c1c0`, or `full`.
- Bank1 completing on the same edge as bank0 is acked -> `full = 010` and `c1c0 = 10` next cycle; `out_valid` stays high.
- Negative extremes: `in_data = -512` and `511` (`DATA_WIDTH = 8`) -> lanes hold `10'h200` and `10'h1FF` exactly.
- `rst_n` pulsed low after 7 samples of bank1 -> all outputs at reset values; the next 16 samples land in bank0 lane 0.
